aes_de_block_loader: RTL and testbench

- Upstream feeder for the AES decryption core.
- Collects a byte stream from a link receiver (UART/FIFO side) into one 128-bit ciphertext block, first byte at [127:120].
- Holds that block stable and asserts de_start for a programmable number of cycles.
- Pulses pt_sample on the cycle the core's plaintext output is valid, so the consumer can latch it.

---
 rtl/aes_de_block_loader_pkg.sv | 20 ++
 rtl/aes_byte_shifter.sv | 63 ++++++
 rtl/aes_de_block_loader.sv | 111 +++++++++++
 tb/tb_aes_de_block_loader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_de_block_loader_pkg.sv
// Shared definitions for the AES decryption block loader.
// Holds the FSM state encoding, block geometry and the default timing
// parameters used by aes_de_block_loader and aes_byte_shifter.
package aes_de_block_loader_pkg;

  localparam int BLOCK_W       = 128;
  localparam int BYTES_PER_BLK = 16;
  // Only the 15 most recent bytes need storing; the 16th arrives on the
  // load edge and is concatenated directly into the output block.
  localparam int SHIFT_W       = BLOCK_W - 8;

  localparam int DE_HOLD_DEF   = 2;
  localparam int TIMEOUT_DEF   = 1000;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_RUN     = 1'b1
  } state_e;

endpackage

// File: rtl/aes_byte_shifter.sv
// Byte-to-block assembler for the AES decryption block loader.
// Shifts accepted bytes into a 120-bit history, counts bytes in the partial
// block and, on the load strobe, publishes the completed 128-bit block.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   shift_en_i   - accept byte_i this cycle
//   load_i       - byte_i completes the block (only honoured with shift_en_i)
//   clr_i        - discard the partial block
//   byte_i       - incoming ciphertext byte
//   block_o      - last completed block (first byte at [127:120])
//   cnt_o        - bytes held in the partial block (0..15)
module aes_byte_shifter
  import aes_de_block_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en_i,
  input  logic               load_i,
  input  logic               clr_i,
  input  logic [7:0]         byte_i,
  output logic [BLOCK_W-1:0] block_o,
  output logic [4:0]         cnt_o
);

  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic [4:0]         cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    block_d = block_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_en_i) begin
      shift_d = {shift_q[SHIFT_W-9:0], byte_i};
      if (load_i) begin
        block_d = {shift_q, byte_i};
        cnt_d   = '0;
      end else if (cnt_q != 5'(BYTES_PER_BLK - 1)) begin
        // Holds at 15; only a block load returns it to zero.
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      block_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      block_q <= block_d;
      cnt_q   <= cnt_d;
    end
  end

  assign block_o = block_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/aes_de_block_loader.sv
// Upstream feeder for the AES decryption core.
// Assembles 16 bytes into a ciphertext block, then holds it stable while
// de_start is high for DE_HOLD cycles; pt_sample marks the last of those
// cycles, when the core's plaintext is valid. A partial block left idle for
// TIMEOUT cycles is discarded and flagged.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   in_byte      - ciphertext byte, qualified by in_valid
//   in_valid     - upstream has a byte
//   in_ready     - loader takes the byte this cycle (COLLECT only)
//   ciphertext   - block to the core, stable while de_start=1
//   de_start     - decryption enable to the core
//   pt_sample    - one-cycle pulse, core plaintext valid
//   byte_cnt     - bytes in the current partial block
//   timeout_err  - one-cycle pulse, partial block discarded
module aes_de_block_loader
  import aes_de_block_loader_pkg::*;
#(
  parameter int DE_HOLD = DE_HOLD_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_byte,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] ciphertext,
  output logic               de_start,
  output logic               pt_sample,
  output logic [4:0]         byte_cnt,
  output logic               timeout_err
);

  localparam int                 RUN_W     = (DE_HOLD > 2) ? $clog2(DE_HOLD) : 1;
  localparam logic [RUN_W-1:0]   RUN_LAST  = RUN_W'(DE_HOLD - 1);
  localparam int                 TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TO_LAST_I);
  localparam bit                 TO_EN     = (TIMEOUT != 0);

  state_e            state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic              err_q;
  logic              accept, load, expire, run_last;

  assign accept   = in_valid && (state_q == ST_COLLECT);
  assign load     = accept && (byte_cnt == 5'(BYTES_PER_BLK - 1));
  assign run_last = (state_q == ST_RUN) && (run_q == RUN_LAST);

  // An accept on the expiry cycle wins, so expiry requires no accept.
  assign expire = TO_EN && (state_q == ST_COLLECT) && (byte_cnt != 5'd0) &&
                  !accept && (timer_q == TO_LAST);

  aes_byte_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (accept),
    .load_i     (load),
    .clr_i      (expire),
    .byte_i     (in_byte),
    .block_o    (ciphertext),
    .cnt_o      (byte_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_COLLECT: if (load)     state_d = ST_RUN;
      ST_RUN:     if (run_last) state_d = ST_COLLECT;
      default:                  state_d = ST_COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_COLLECT);
    de_start  = (state_q == ST_RUN);
    pt_sample = run_last;
  end

  always_comb begin
    run_d = '0;
    if (state_q == ST_RUN && !run_last) run_d = run_q + 1'b1;
  end

  always_comb begin
    timer_d = '0;
    if (TO_EN && state_q == ST_COLLECT && byte_cnt != 5'd0 && !accept && !expire)
      timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      run_q   <= run_d;
      timer_q <= timer_d;
      err_q   <= expire;
    end
  end

  assign timeout_err = err_q;

endmodule

// File: tb/tb_aes_de_block_loader.sv
// Directed bench for aes_de_block_loader: instance A (DE_HOLD=2, TIMEOUT=20)
// covers assembly, gaps and timeout; instance B (DE_HOLD=4) covers
// back-pressure during RUN and reset in mid-RUN.
module tb_aes_de_block_loader;

  logic         clk;
  logic         rst;
  logic [7:0]   in_byte_a, in_byte_b;
  logic         in_valid_a, in_valid_b;
  logic         in_ready_a, in_ready_b;
  logic [127:0] ct_a, ct_b;
  logic         de_a, de_b, pt_a, pt_b, err_a, err_b;
  logic [4:0]   cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;

  aes_de_block_loader #(.DE_HOLD(2), .TIMEOUT(20), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_byte(in_byte_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .ciphertext(ct_a), .de_start(de_a),
    .pt_sample(pt_a), .byte_cnt(cnt_a), .timeout_err(err_a)
  );

  aes_de_block_loader #(.DE_HOLD(4), .TIMEOUT(20), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_byte(in_byte_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .ciphertext(ct_b), .de_start(de_b),
    .pt_sample(pt_b), .byte_cnt(cnt_b), .timeout_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] b);
    in_byte_a  = b;
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    in_byte_b  = b;
    in_valid_b = 1'b1;
    step();
    in_valid_b = 1'b0;
  endtask

  logic [127:0] ct1;
  logic [127:0] exp_blk;
  int           err_seen;
  int           cnt_bad;
  int           pt_seen;

  initial begin
    ct1        = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    rst        = 1'b1;
    in_byte_a  = 8'h00;
    in_byte_b  = 8'h00;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", 128'(in_ready_a), 128'd1);
    chk("rst_ct",       ct_a,             128'd0);
    chk("rst_de",       128'(de_a),       128'd0);
    chk("rst_pt",       128'(pt_a),       128'd0);
    chk("rst_cnt",      128'(cnt_a),      128'd0);
    chk("rst_err",      128'(err_a),      128'd0);

    // FIPS-197 C.1 ciphertext, back to back
    for (int i = 0; i < 16; i++) begin
      send_a(ct1[127 - 8*i -: 8]);
      if (i < 15) chk("t1_cnt", 128'(cnt_a), 128'(i + 1));
    end
    chk("t1_ct",       ct_a,              ct1);
    chk("t1_de_c17",   128'(de_a),        128'd1);
    chk("t1_pt_c17",   128'(pt_a),        128'd0);
    chk("t1_rdy_c17",  128'(in_ready_a),  128'd0);
    chk("t1_cnt_c17",  128'(cnt_a),       128'd0);
    step();
    chk("t1_de_c18",   128'(de_a),        128'd1);
    chk("t1_pt_c18",   128'(pt_a),        128'd1);
    chk("t1_ct_c18",   ct_a,              ct1);
    step();
    chk("t1_de_c19",   128'(de_a),        128'd0);
    chk("t1_pt_c19",   128'(pt_a),        128'd0);
    chk("t1_rdy_c19",  128'(in_ready_a),  128'd1);
    chk("t1_ct_keep",  ct_a,              ct1);

    // Same block with random gaps shorter than TIMEOUT
    err_seen = 0;
    cnt_bad  = 0;
    for (int i = 0; i < 16; i++) begin
      int gap;
      gap = $urandom_range(0, 8);
      for (int g = 0; g < gap; g++) begin
        step();
        if (err_a !== 1'b0) err_seen++;
      end
      send_a(ct1[127 - 8*i -: 8]);
      if (err_a !== 1'b0) err_seen++;
      if (i < 15 && cnt_a !== 5'(i + 1)) cnt_bad++;
    end
    chk("t2_no_err",  128'(err_seen), 128'd0);
    chk("t2_cnt_seq", 128'(cnt_bad),  128'd0);
    chk("t2_ct",      ct_a,           ct1);
    chk("t2_de",      128'(de_a),     128'd1);
    step();
    step();

    // 5 bytes then idle until timeout
    for (int i = 0; i < 5; i++) send_a(8'hf0 + 8'(i));
    err_seen = 0;
    for (int k = 0; k < 19; k++) begin
      step();
      if (err_a !== 1'b0) err_seen++;
    end
    chk("t3_no_early_err", 128'(err_seen), 128'd0);
    chk("t3_cnt_held",     128'(cnt_a),    128'd5);
    step();
    chk("t3_err_pulse",    128'(err_a),    128'd1);
    chk("t3_cnt_clr",      128'(cnt_a),    128'd0);
    step();
    chk("t3_err_one",      128'(err_a),    128'd0);
    for (int i = 0; i < 16; i++) send_a(8'h10 + 8'(i));
    chk("t3_clean_ct", ct_a, 128'h101112131415161718191a1b1c1d1e1f);
    chk("t3_clean_de", 128'(de_a), 128'd1);
    step();
    step();

    // Accept on the expiry cycle wins and restarts the counter
    for (int i = 0; i < 3; i++) send_a(8'h30 + 8'(i));
    err_seen = 0;
    for (int k = 0; k < 19; k++) begin
      step();
      if (err_a !== 1'b0) err_seen++;
    end
    send_a(8'h33);
    if (err_a !== 1'b0) err_seen++;
    chk("t6_cnt_inc", 128'(cnt_a), 128'd4);
    for (int k = 0; k < 19; k++) begin
      step();
      if (err_a !== 1'b0) err_seen++;
    end
    chk("t6_no_err",   128'(err_seen), 128'd0);
    chk("t6_cnt_keep", 128'(cnt_a),    128'd4);
    step();
    chk("t6_err_late", 128'(err_a),    128'd1);
    chk("t6_cnt_clr",  128'(cnt_a),    128'd0);
    step();

    // Instance B: byte held during a 4-cycle RUN
    for (int i = 0; i < 16; i++) send_b(8'ha0 + 8'(i));
    exp_blk    = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
    in_byte_b  = 8'h55;
    in_valid_b = 1'b1;
    pt_seen    = 0;
    for (int r = 1; r <= 4; r++) begin
      chk("t4_rdy_low", 128'(in_ready_b), 128'd0);
      chk("t4_de_high", 128'(de_b),       128'd1);
      chk("t4_ct_hold", ct_b,             exp_blk);
      if (pt_b === 1'b1) pt_seen = r;
      step();
    end
    chk("t4_pt_cycle", 128'(pt_seen),    128'd4);
    chk("t4_rdy_back", 128'(in_ready_b), 128'd1);
    chk("t4_de_low",   128'(de_b),       128'd0);
    chk("t4_cnt0",     128'(cnt_b),      128'd0);
    step();
    in_valid_b = 1'b0;
    chk("t4_held_acc", 128'(cnt_b), 128'd1);
    for (int i = 1; i < 16; i++) send_b(8'(i));
    chk("t4_ct_next", ct_b, 128'h55010203040506070809_0a0b0c0d0e0f);

    // Reset on the 2nd RUN cycle of instance B
    step();
    chk("t5_run2_de", 128'(de_b), 128'd1);
    chk("t5_run2_pt", 128'(pt_b), 128'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_de",  128'(de_b),       128'd0);
    chk("t5_pt",  128'(pt_b),       128'd0);
    chk("t5_cnt", 128'(cnt_b),      128'd0);
    chk("t5_ct",  ct_b,             128'd0);
    chk("t5_rdy", 128'(in_ready_b), 128'd1);
    pt_seen = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (pt_b !== 1'b0 || de_b !== 1'b0) pt_seen++;
    end
    chk("t5_no_late_pt", 128'(pt_seen), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
